note_period_meter: RTL and testbench

NOTE_PERIOD_METER -- requirements
Module: note_period_meter

---
 rtl/note_period_meter.sv | 146 ++++++++++++++
 tb/tb_note_period_meter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/note_period_meter.sv
// Measures the half-period of a square-wave audio line in clocks and publishes
// it once LOCK_N consecutive measurements agree within TOL.
module note_period_meter #(
    parameter int CNT_W    = 13,
    parameter int MAX_HALF = 8191,
    parameter int MIN_HALF = 2,
    parameter int TOL      = 1,
    parameter int LOCK_N   = 4
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic             iEnable,
    input  logic             iAudio,
    output logic [CNT_W-1:0] oHalfPeriod,
    output logic             oValid,
    output logic             oUpdate,
    output logic             oSilent
);
    localparam int AW = CNT_W + 1;
    localparam int MW = $clog2(LOCK_N + 1);
    localparam logic [AW-1:0] SAT  = AW'(MAX_HALF + 1);
    localparam logic [AW-1:0] MINV = AW'(MIN_HALF);
    localparam logic [AW-1:0] MAXV = AW'(MAX_HALF);
    localparam logic [AW-1:0] TOLV = AW'(TOL);
    localparam logic [MW-1:0] LOCKV = MW'(LOCK_N);

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, LOCKED} state_t;

    state_t            state, stateNxt;
    logic              sync1, sync2, hist;
    logic [AW-1:0]     cnt, last, lastNxt;
    logic [MW-1:0]     match, matchNxt, matchInc;
    logic [CNT_W-1:0]  halfNxt;
    logic              validNxt, updNxt, silentNxt;
    logic              audioEdge, measOk, nearLast, nearHalf, timeout;

    function automatic logic [AW-1:0] absDiff(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    assign audioEdge = sync2 ^ hist;
    assign measOk    = (cnt >= MINV) && (cnt <= MAXV);
    assign nearLast  = (last != '0) && (absDiff(cnt, last) <= TOLV);
    assign nearHalf  = absDiff(cnt, {1'b0, oHalfPeriod}) <= TOLV;
    assign matchInc  = match + 1'b1;
    // A saturated count with an edge in the same cycle is an invalid measurement.
    assign timeout   = (cnt == SAT) && !audioEdge;

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state       <= IDLE;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            hist        <= 1'b0;
            cnt         <= '0;
            last        <= '0;
            match       <= '0;
            oHalfPeriod <= '0;
            oValid      <= 1'b0;
            oUpdate     <= 1'b0;
            oSilent     <= 1'b1;
        end else begin
            sync1       <= iAudio;
            sync2       <= sync1;
            hist        <= sync2;
            if (audioEdge)       cnt <= AW'(1);
            else if (cnt != SAT) cnt <= cnt + 1'b1;
            state       <= stateNxt;
            last        <= lastNxt;
            match       <= matchNxt;
            oHalfPeriod <= halfNxt;
            oValid      <= validNxt;
            oUpdate     <= updNxt;
            oSilent     <= silentNxt;
        end
    end

    always_comb begin
        stateNxt  = state;
        lastNxt   = last;
        matchNxt  = match;
        halfNxt   = oHalfPeriod;
        validNxt  = oValid;
        updNxt    = 1'b0;
        silentNxt = oSilent;
        if (!iEnable) begin
            stateNxt  = IDLE;
            lastNxt   = '0;
            matchNxt  = '0;
            halfNxt   = '0;
            validNxt  = 1'b0;
            silentNxt = 1'b1;
        end else begin
            case (state)
                IDLE: stateNxt = WAIT_EDGE;
                WAIT_EDGE: begin
                    if (audioEdge) begin
                        stateNxt = MEASURE;
                        lastNxt  = '0;
                        matchNxt = '0;
                    end
                end
                MEASURE: begin
                    if (audioEdge) begin
                        if (measOk) begin
                            lastNxt = cnt;
                            if (nearLast && matchInc == LOCKV) begin
                                stateNxt  = LOCKED;
                                matchNxt  = '0;
                                halfNxt   = cnt[CNT_W-1:0];
                                validNxt  = 1'b1;
                                silentNxt = 1'b0;
                                updNxt    = 1'b1;
                            end else if (nearLast) begin
                                matchNxt = matchInc;
                            end else begin
                                matchNxt = '0;
                            end
                        end else begin
                            lastNxt  = '0;
                            matchNxt = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Hysteresis: small drift around the published value is ignored.
                    if (audioEdge && !(measOk && nearHalf)) begin
                        stateNxt = MEASURE;
                        lastNxt  = measOk ? cnt : '0;
                        matchNxt = '0;
                        validNxt = 1'b0;
                    end
                end
                default: stateNxt = IDLE;
            endcase
            if ((state == MEASURE || state == LOCKED) && timeout) begin
                stateNxt  = WAIT_EDGE;
                lastNxt   = '0;
                matchNxt  = '0;
                halfNxt   = '0;
                validNxt  = 1'b0;
                silentNxt = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_note_period_meter.sv
// Directed and randomized checks of note_period_meter against an edge-level
// behavioural model of the measurement and lock rules.
module tb_note_period_meter;
    localparam int CNT_W = 13, MAX_HALF = 8191, MIN_HALF = 2, TOL = 1, LOCK_N = 4;

    logic iClk = 1'b0, iReset_n = 1'b0, iEnable = 1'b0, iAudio = 1'b0;
    logic [CNT_W-1:0] oHalfPeriod;
    logic oValid, oUpdate, oSilent;

    note_period_meter #(.CNT_W(CNT_W), .MAX_HALF(MAX_HALF), .MIN_HALF(MIN_HALF),
                        .TOL(TOL), .LOCK_N(LOCK_N)) dut (
        .iClk(iClk), .iReset_n(iReset_n), .iEnable(iEnable), .iAudio(iAudio),
        .oHalfPeriod(oHalfPeriod), .oValid(oValid), .oUpdate(oUpdate), .oSilent(oSilent));

    always #5 iClk = ~iClk;

    int errors = 0, checks = 0, updSeen = 0, sinceTog = 0;

    // Model: tracking = a first edge has been seen since enable/timeout.
    bit mTrack = 0, mLock = 0, mValid = 0, mSilent = 1;
    int mLast = 0, mMatch = 0, mHalf = 0, mUpd = 0;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void modelClear();
        mTrack = 0; mLock = 0; mValid = 0; mSilent = 1;
        mLast = 0; mMatch = 0; mHalf = 0;
    endfunction

    function automatic void modelEdge(input int m);
        bit ok;
        ok = (m >= MIN_HALF) && (m <= MAX_HALF);
        if (!mTrack) begin
            mTrack = 1; mLast = 0; mMatch = 0;
        end else if (mLock) begin
            if (!(ok && iabs(m - mHalf) <= TOL)) begin
                mLock = 0; mValid = 0; mMatch = 0; mLast = ok ? m : 0;
            end
        end else if (!ok) begin
            mMatch = 0; mLast = 0;
        end else begin
            if (mLast != 0 && iabs(m - mLast) <= TOL) mMatch++;
            else mMatch = 0;
            mLast = m;
            if (mMatch == LOCK_N) begin
                mLock = 1; mHalf = m; mValid = 1; mSilent = 0; mUpd++; mMatch = 0;
            end
        end
    endfunction

    task automatic tick();
        @(posedge iClk); #1;
        sinceTog++;
        if (oUpdate === 1'b1) updSeen++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkModel(input string tag);
        chk({tag, ".valid"}, 32'(oValid), 32'(mValid));
        chk({tag, ".half"}, 32'(oHalfPeriod), 32'(mHalf));
        chk({tag, ".updates"}, 32'(updSeen), 32'(mUpd));
    endtask

    task automatic edgeAfter(input int hp);
        while (sinceTog < hp) tick();
        iAudio = ~iAudio;
        sinceTog = 0;
        modelEdge(hp);
    endtask

    initial begin
        int base, hp;
        bit jit;
        // Reset
        ticks(2);
        chk("rst.half", 32'(oHalfPeriod), 0);
        chk("rst.valid", 32'(oValid), 0);
        chk("rst.update", 32'(oUpdate), 0);
        chk("rst.silent", 32'(oSilent), 1);
        iReset_n = 1'b1; iEnable = 1'b1;
        ticks(3);

        // Lock at 100: no lock after 5 edges, lock on the 6th
        repeat (5) edgeAfter(100);
        ticks(8);
        chkModel("lock5");
        edgeAfter(100);
        ticks(8);
        chkModel("lock6");
        chk("lock6.const", 32'(oHalfPeriod), 100);
        chk("lock6.silent", 32'(oSilent), 0);

        // Jitter 99/101 must not disturb the lock
        for (int i = 0; i < 10; i++) edgeAfter((i % 2 == 0) ? 99 : 101);
        ticks(8);
        chkModel("jitter");
        chk("jitter.const", 32'(oHalfPeriod), 100);

        // Retune to 50
        edgeAfter(50);
        ticks(8);
        chkModel("retune1");
        for (int i = 0; i < 3; i++) edgeAfter(50);
        ticks(8);
        chkModel("retune4");
        edgeAfter(50);
        ticks(8);
        chkModel("retune5");
        chk("retune5.const", 32'(oHalfPeriod), 50);

        // Silence after lock
        while (sinceTog < 8000) tick();
        chkModel("silence.pre");
        while (sinceTog < 8200) tick();
        modelClear();
        chkModel("silence");
        chk("silence.silent", 32'(oSilent), 1);

        // Glitch during MEASURE clears the match run
        edgeAfter(60); edgeAfter(60); edgeAfter(60);
        edgeAfter(30); edgeAfter(1); edgeAfter(29);
        for (int i = 0; i < 4; i++) edgeAfter(60);
        ticks(8);
        chkModel("glitch.nolock");
        chk("glitch.valid0", 32'(oValid), 0);
        edgeAfter(60);
        ticks(8);
        chkModel("glitch.lock");

        // Disable while locked
        iEnable = 1'b0;
        tick();
        modelClear();
        chkModel("disable");
        chk("disable.silent", 32'(oSilent), 1);
        iEnable = 1'b1;
        ticks(2);

        // Randomized periods, mostly near a base, sometimes arbitrary
        for (int r = 0; r < 4; r++) begin
            base = $urandom_range(20, 200);
            jit = 1'($urandom_range(0, 1));
            for (int i = 0; i < 10; i++) begin
                if ($urandom_range(0, 99) < 15) hp = $urandom_range(8, 300);
                else hp = base + (jit ? $urandom_range(0, 2) - 1 : 0);
                edgeAfter(hp);
                ticks(6);
                chkModel($sformatf("rand%0d.%0d", r, i));
            end
        end

        // Reset mid-lock
        repeat (6) edgeAfter(80);
        ticks(8);
        chkModel("prerst");
        chk("prerst.valid1", 32'(oValid), 1);
        iReset_n = 1'b0;
        tick();
        modelClear();
        chkModel("midrst");
        chk("midrst.update", 32'(oUpdate), 0);
        chk("midrst.silent", 32'(oSilent), 1);
        ticks(3);
        chk("midrst.hold", 32'(updSeen), 32'(mUpd));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
